serial_monitor: RTL and testbench

Serial boot monitor sitting between the UART and the `cpu` core. It drives the core's control interface, accepting host commands over the UART receive path to load RAM, dump RAM and start execution at a given address. It owns the RAM ports and the UART while the core is halted. It hands both to the core while it runs and takes them back when the core reports `halted`.

---
 rtl/serial_monitor.sv | 169 ++++++++++++++++
 tb/tb_serial_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_monitor.sv
// Serial boot monitor: decodes W/R/G host commands from the UART, loads and
// dumps RAM, and hands the RAM/UART ports to the core while it runs.
module serial_monitor #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  output logic [addr_width-1:0] mon_raddr,
  input  logic [7:0]            dread,
  output logic [addr_width-1:0] mon_waddr,
  output logic [7:0]            mon_dwrite,
  output logic                  mon_write_en,
  output logic                  bus_own,
  output logic                  cpu_start,
  output logic [addr_width-1:0] startaddr,
  input  logic                  cpu_halted
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] REP_K = 8'h4B;
  localparam logic [7:0] REP_H = 8'h48;
  localparam logic [7:0] REP_Q = 8'h3F;
  localparam logic [addr_width-1:0] ADDR_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDRH, S_ADDRL, S_LEN, S_WDATA, S_RADDR, S_RWAIT,
    S_RDATA, S_TXWAIT, S_TXGUARD, S_GO, S_RUN
  } state_t;

  state_t                state_q;
  logic [7:0]            cmd_q;
  logic [addr_width-9:0] ah_q;
  logic [addr_width-1:0] addr_q;
  logic [8:0]            cnt_q;
  logic                  rd_more_q;
  logic [7:0]            tx_byte_q;
  logic                  transmit_q;
  logic [addr_width-1:0] raddr_q;
  logic [addr_width-1:0] waddr_q;
  logic [7:0]            dwrite_q;
  logic                  wen_q;
  logic                  bus_own_q;
  logic                  cpu_start_q;
  logic [addr_width-1:0] startaddr_q;

  logic [addr_width-1:0] addr_inc_d;
  logic [addr_width-1:0] addr_ld_d;
  logic [8:0]            cnt_dec_d;
  logic [8:0]            cnt_ld_d;

  assign addr_inc_d = addr_q + ADDR_ONE;
  assign addr_ld_d  = {ah_q, rx_byte};
  assign cnt_dec_d  = cnt_q - 9'd1;
  // A length byte of zero encodes a full 256-byte transfer.
  assign cnt_ld_d   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      ah_q        <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rd_more_q   <= 1'b0;
      tx_byte_q   <= '0;
      transmit_q  <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      dwrite_q    <= '0;
      wen_q       <= 1'b0;
      bus_own_q   <= 1'b1;
      cpu_start_q <= 1'b0;
      startaddr_q <= '0;
    end else begin
      transmit_q  <= 1'b0;
      wen_q       <= 1'b0;
      cpu_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (received) begin
          cmd_q   <= rx_byte;
          state_q <= S_CMD;
        end
        S_CMD: begin
          if (cmd_q == CMD_W || cmd_q == CMD_R || cmd_q == CMD_G) begin
            state_q <= S_ADDRH;
          end else begin
            tx_byte_q <= REP_Q;
            rd_more_q <= 1'b0;
            state_q   <= S_TXWAIT;
          end
        end
        S_ADDRH: if (received) begin
          ah_q    <= rx_byte[addr_width-9:0];
          state_q <= S_ADDRL;
        end
        S_ADDRL: if (received) begin
          addr_q  <= addr_ld_d;
          state_q <= (cmd_q == CMD_G) ? S_GO : S_LEN;
        end
        S_LEN: if (received) begin
          cnt_q   <= cnt_ld_d;
          state_q <= (cmd_q == CMD_W) ? S_WDATA : S_RADDR;
        end
        S_WDATA: if (received) begin
          wen_q    <= 1'b1;
          waddr_q  <= addr_q;
          dwrite_q <= rx_byte;
          addr_q   <= addr_inc_d;
          cnt_q    <= cnt_dec_d;
          if (cnt_q == 9'd1) begin
            tx_byte_q <= REP_K;
            rd_more_q <= 1'b0;
            state_q   <= S_TXWAIT;
          end
        end
        S_RADDR: begin
          raddr_q <= addr_q;
          state_q <= S_RWAIT;
        end
        // Registered RAM: data for raddr_q is on dread two edges after it is set.
        S_RWAIT: state_q <= S_RDATA;
        S_RDATA: begin
          tx_byte_q <= dread;
          addr_q    <= addr_inc_d;
          cnt_q     <= cnt_dec_d;
          rd_more_q <= (cnt_q != 9'd1);
          state_q   <= S_TXWAIT;
        end
        S_TXWAIT: if (!is_transmitting) begin
          transmit_q <= 1'b1;
          state_q    <= S_TXGUARD;
        end
        // UART busy lags the strobe by a cycle, so skip one sample of it.
        S_TXGUARD: state_q <= rd_more_q ? S_RADDR : S_IDLE;
        S_GO: begin
          startaddr_q <= addr_q;
          cpu_start_q <= 1'b1;
          bus_own_q   <= 1'b0;
          state_q     <= S_RUN;
        end
        S_RUN: if (cpu_halted) begin
          bus_own_q <= 1'b1;
          tx_byte_q <= REP_H;
          rd_more_q <= 1'b0;
          state_q   <= S_TXWAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_byte      = tx_byte_q;
  assign transmit     = transmit_q;
  assign mon_raddr    = raddr_q;
  assign mon_waddr    = waddr_q;
  assign mon_dwrite   = dwrite_q;
  assign mon_write_en = wen_q;
  assign bus_own      = bus_own_q;
  assign cpu_start    = cpu_start_q;
  assign startaddr    = startaddr_q;

endmodule

// File: tb/tb_serial_monitor.sv
// Randomized bench for serial_monitor: host-command driver, registered RAM,
// UART busy model, and a memory-image reference model of the command protocol.
module tb_serial_monitor;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          received = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          is_transmitting = 1'b0;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic [AW-1:0] mon_raddr;
  logic [7:0]    dread;
  logic [AW-1:0] mon_waddr;
  logic [7:0]    mon_dwrite;
  logic          mon_write_en;
  logic          bus_own;
  logic          cpu_start;
  logic [AW-1:0] startaddr;
  logic          cpu_halted = 1'b0;

  always #5 clk = ~clk;

  serial_monitor #(.addr_width(AW)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .mon_raddr(mon_raddr), .dread(dread), .mon_waddr(mon_waddr),
    .mon_dwrite(mon_dwrite), .mon_write_en(mon_write_en), .bus_own(bus_own),
    .cpu_start(cpu_start), .startaddr(startaddr), .cpu_halted(cpu_halted)
  );

  // Registered RAM driven by the monitor ports
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    dread <= mem[mon_raddr];
    if (mon_write_en) mem[mon_waddr] <= mon_dwrite;
  end

  logic [7:0] ref_mem [DEPTH];
  int nvec = 0, nerr = 0;
  int viol = 0, nstart = 0;
  int busy_len = 2, busy_cnt = 0;
  logic [7:0] txq[$];
  int wa[$], wd[$];
  logic rx_edge = 1'b0;

  always @(posedge clk) rx_edge <= received;

  always @(negedge clk) begin
    if (transmit) begin
      if (is_transmitting) viol++;
      txq.push_back(tx_byte);
    end
    if (mon_write_en) begin
      if (!rx_edge) viol++;
      wa.push_back(int'(mon_waddr));
      wd.push_back(int'(mon_dwrite));
    end
    if (cpu_start) begin
      nstart++;
      if (bus_own) viol++;
    end
    if (transmit) begin
      busy_cnt = busy_len;
      is_transmitting = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) is_transmitting = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    received = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (txq.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("tx_timeout", txq.size(), n);
    t = 0;
    while (is_transmitting && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_tx(input string tag, input logic [7:0] e[$]);
    drain(e.size());
    chk({tag, "_txcount"}, txq.size(), e.size());
    for (int i = 0; i < e.size() && i < txq.size(); i++) chk({tag, "_tx"}, txq[i], e[i]);
    txq.delete();
  endtask

  function automatic int base_of(input logic [7:0] ah, input logic [7:0] al);
    return ((int'(ah) * 256) + int'(al)) % DEPTH;
  endfunction

  task automatic do_write(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] d[$]);
    int base = base_of(ah, al);
    int n = d.size();
    logic [7:0] e[$];
    wa.delete(); wd.delete();
    send(8'h57); send(ah); send(al); send(8'(n));
    for (int i = 0; i < n; i++) begin
      ref_mem[(base + i) % DEPTH] = d[i];
      send(d[i]);
    end
    e = {8'h4B};
    check_tx("W", e);
    chk("W_strobes", wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk("W_addr", wa[i], (base + i) % DEPTH);
      chk("W_data", wd[i], int'(d[i]));
    end
    wa.delete(); wd.delete();
  endtask

  task automatic do_read(input logic [7:0] ah, input logic [7:0] al, input int n);
    int base = base_of(ah, al);
    logic [7:0] e[$];
    wa.delete();
    for (int i = 0; i < n; i++) e.push_back(ref_mem[(base + i) % DEPTH]);
    send(8'h52); send(ah); send(al); send(8'(n));
    check_tx("R", e);
    chk("R_nowrite", wa.size(), 0);
  endtask

  function automatic void rand_data(input int n, output logic [7:0] d[$]);
    d.delete();
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] d[$];
    logic [7:0] e[$];
    logic [7:0] b;
    int r;

    repeat (3) @(negedge clk);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_raddr", mon_raddr, 0);
    chk("rst_waddr", mon_waddr, 0);
    chk("rst_dwrite", mon_dwrite, 0);
    chk("rst_wen", mon_write_en, 0);
    chk("rst_bus_own", bus_own, 1);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_startaddr", startaddr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fill the whole RAM with N=0 (256-byte) writes
    busy_len = 1;
    rand_data(256, d); do_write(8'h00, 8'h00, d);
    rand_data(256, d); do_write(8'h01, 8'h00, d);

    // Halt pulse outside RUN is ignored
    @(negedge clk) cpu_halted = 1'b1;
    @(negedge clk) cpu_halted = 1'b0;
    repeat (10) @(negedge clk);
    chk("halt_idle_tx", txq.size(), 0);
    chk("halt_idle_bus_own", bus_own, 1);

    d = {8'hAA, 8'hBB, 8'hCC};
    do_write(8'h00, 8'h10, d);

    // Wrap-around read with a long UART busy period
    d = {8'h5A}; do_write(8'h01, 8'hFF, d);
    d = {8'hA5}; do_write(8'h00, 8'h00, d);
    busy_len = 100;
    do_read(8'h01, 8'hFF, 2);
    busy_len = 2;

    // Reset after 2 of 4 data bytes
    wa.delete(); wd.delete();
    send(8'h57); send(8'h00); send(8'h10); send(8'h04); send(8'hB0); send(8'hB1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    ref_mem[16] = 8'hB0;
    ref_mem[17] = 8'hB1;
    @(negedge clk);
    chk("rstW_strobes", wa.size(), 2);
    wa.delete(); wd.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("rstW_bus_own", bus_own, 1);
    repeat (20) @(negedge clk);
    chk("rstW_no_K", txq.size(), 0);
    do_read(8'h00, 8'h10, 2);

    // Go / run / halt
    send(8'h47); send(8'h00); send(8'h40);
    chk("G_startaddr", startaddr, 9'h040);
    chk("G_start_pulses", nstart, 1);
    chk("G_bus_own", bus_own, 0);
    send(8'h57); send(8'h00); send(8'h00); send(8'h01); send(8'h77);
    repeat (10) @(negedge clk);
    chk("RUN_no_write", wa.size(), 0);
    chk("RUN_no_tx", txq.size(), 0);
    @(negedge clk) cpu_halted = 1'b1;
    @(negedge clk) cpu_halted = 1'b0;
    chk("H_bus_own", bus_own, 1);
    e = {8'h48};
    check_tx("H", e);
    chk("H_startaddr_hold", startaddr, 9'h040);

    // Reset while running
    send(8'h47); send(8'h03); send(8'h9C);
    chk("G2_startaddr", startaddr, 9'h19C);
    chk("G2_start_pulses", nstart, 2);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rstRUN_bus_own", bus_own, 1);
    chk("rstRUN_startaddr", startaddr, 0);
    repeat (10) @(negedge clk);
    chk("rstRUN_no_tx", txq.size(), 0);

    send(8'h21);
    e = {8'h3F};
    check_tx("inv", e);

    for (int it = 0; it < 30; it++) begin
      busy_len = $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        rand_data($urandom_range(1, 8), d);
        do_write(8'($urandom), 8'($urandom), d);
      end else if (r < 8) begin
        do_read(8'($urandom), 8'($urandom), $urandom_range(1, 10));
      end else begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52 || b == 8'h47) b = 8'($urandom);
        send(b);
        e = {8'h3F};
        check_tx("rand_inv", e);
      end
    end

    busy_len = 1;
    do_read(8'h00, 8'h00, 256);

    chk("protocol_violations", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
